// File: rtl/pf_iod_train_pkg.sv
// pf_iod_train_pkg
// Shared definitions for the IOD delay-line training controller:
//   - train_state_e : training FSM states
//   - DIR_INC/DIR_DEC : DELAY_LINE_DIRECTION encodings
//   - cnt_w()       : bits needed to hold a counter value 0..max_val
package pf_iod_train_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    SAMPLE,
    DECIDE,
    MOVE,
    NEXT,
    DONE_ST
  } train_state_e;

  localparam logic DIR_INC = 1'b1;  // add delay
  localparam logic DIR_DEC = 1'b0;  // remove delay

  // Width of a counter that must hold every value in 0..max_val (min 1 bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pf_iod_train_win_cnt.sv
// pf_iod_train_win_cnt
// Early/late observation-window counter shared by all lanes; the top muxes the
// active lane's eye-monitor flags onto early_in/late_in.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   clr               : zero both counters (wins over en)
//   en                : count enable (one window cycle)
//   early_in, late_in : flags of the active lane
//   early_cnt, late_cnt : counts, saturating at all-ones
module pf_iod_train_win_cnt
  import pf_iod_train_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             early_in,
  input  logic             late_in,
  output logic [CNT_W-1:0] early_cnt,
  output logic [CNT_W-1:0] late_cnt
);

  logic [CNT_W-1:0] early_cnt_q, early_cnt_d;
  logic [CNT_W-1:0] late_cnt_q, late_cnt_d;

  always_comb begin
    early_cnt_d = early_cnt_q;
    late_cnt_d  = late_cnt_q;
    if (clr) begin
      early_cnt_d = '0;
      late_cnt_d  = '0;
    end else if (en) begin
      // Sized to hold a full window, so saturation is only a safety net.
      if (early_in && (early_cnt_q != '1)) early_cnt_d = early_cnt_q + CNT_W'(1);
      if (late_in && (late_cnt_q != '1))   late_cnt_d  = late_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      early_cnt_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      early_cnt_q <= early_cnt_d;
      late_cnt_q  <= late_cnt_d;
    end
  end

  assign early_cnt = early_cnt_q;
  assign late_cnt  = late_cnt_q;

endmodule

// File: rtl/pf_iod_dly_train.sv
// pf_iod_dly_train
// Sequential multi-lane RX delay-line training controller. Lanes are trained
// one at a time (0..LANES-1): load INIT_TAP, clear eye flags, settle, count
// EARLY/LATE over a window, then lock, fail or move one tap and repeat.
// Ports:
//   FAB_CLK, RX_SYNC_RST    : clock, synchronous active-high reset
//   START                   : one-cycle start pulse (ignored while BUSY)
//   EYE_MONITOR_EARLY/LATE  : per-lane eye-monitor flags
//   DELAY_LINE_OUT_OF_RANGE : per-lane range flag
//   DELAY_LINE_LOAD/MOVE/DIRECTION, EYE_MONITOR_CLEAR_FLAGS : per-lane pulses
//   BUSY, DONE              : run status
//   LANE_LOCK, LANE_FAIL    : sticky per-lane results
//   TAP_OUT                 : final tap per lane, lane i at [i*TAP_W +: TAP_W]
// Optional macro IOD_TRAIN_PERIODIC_EN adds RETRAIN_PERIOD / RETRAIN_HOLD and
// periodic tracking passes over locked lanes after the first DONE.
// Handshake: START is accepted only while BUSY is low; BUSY rises the cycle
// after an accepted START and falls in the single cycle DONE is high. There is
// no backpressure; every pulse output is a registered one-cycle strobe.
module pf_iod_dly_train
  import pf_iod_train_pkg::*;
#(
  parameter int LANES         = 10,
  parameter int TAP_W         = 8,
  parameter int INIT_TAP      = 1,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int HYST          = 2,
  parameter int MAX_STEPS     = 64
`ifdef IOD_TRAIN_PERIODIC_EN
  ,
  parameter int RETRAIN_PERIOD = 65536
`endif
) (
  input  logic                   FAB_CLK,
  input  logic                   RX_SYNC_RST,
  input  logic                   START,
  input  logic [LANES-1:0]       EYE_MONITOR_EARLY,
  input  logic [LANES-1:0]       EYE_MONITOR_LATE,
  input  logic [LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
`ifdef IOD_TRAIN_PERIODIC_EN
  input  logic                   RETRAIN_HOLD,
`endif
  output logic [LANES-1:0]       DELAY_LINE_LOAD,
  output logic [LANES-1:0]       DELAY_LINE_MOVE,
  output logic [LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [LANES-1:0]       LANE_LOCK,
  output logic [LANES-1:0]       LANE_FAIL,
  output logic [LANES*TAP_W-1:0] TAP_OUT
);

  localparam int LW = cnt_w(LANES - 1);
  localparam int SW = cnt_w(MAX_STEPS);
  localparam int CW = cnt_w(SAMPLE_CYCLES);
  localparam int YW = cnt_w((SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES);

  train_state_e state_q, state_d;
  logic [LW-1:0]          lane_q, lane_d, lane_nx;
  logic [TAP_W-1:0]       tap_q, tap_d;
  logic [SW-1:0]          steps_q, steps_d;
  logic [YW-1:0]          cyc_q, cyc_d;
  logic [1:0]             rev_q, rev_d;
  logic                   dir_q, dir_d;
  logic                   last_dir_q, last_dir_d;
  logic                   oor_pend_q, oor_pend_d;
  logic [LANES-1:0]       load_q, load_d, move_q, move_d, diro_q, diro_d, clr_q, clr_d;
  logic [LANES-1:0]       lock_q, lock_d, fail_q, fail_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [LANES*TAP_W-1:0] tap_out_q, tap_out_d;

  logic [CW-1:0] early_cnt, late_cnt, diff;
  logic          early_lane, late_lane, oor_lane, oor_seen;
  logic          dir_now, reversal, trk, rt_fire;

`ifdef IOD_TRAIN_PERIODIC_EN
  localparam int RW = cnt_w(RETRAIN_PERIOD - 1);
  logic          trk_q, trk_d, armed_q, armed_d;
  logic [RW-1:0] rt_cnt_q, rt_cnt_d;
  assign trk     = trk_q;
  assign rt_fire = armed_q && (rt_cnt_q == RW'(RETRAIN_PERIOD - 1)) && !RETRAIN_HOLD;
`else
  assign trk     = 1'b0;
  assign rt_fire = 1'b0;
`endif

  function automatic logic [LANES-1:0] lane_oh(input logic [LW-1:0] l);
    return LANES'(1) << l;
  endfunction

  assign early_lane = EYE_MONITOR_EARLY[lane_q];
  assign late_lane  = EYE_MONITOR_LATE[lane_q];
  assign oor_lane   = DELAY_LINE_OUT_OF_RANGE[lane_q];
  assign lane_nx    = lane_q + LW'(1);

  pf_iod_train_win_cnt #(.CNT_W(CW)) u_win_cnt (
    .clk       (FAB_CLK),
    .rst       (RX_SYNC_RST),
    .clr       (state_q == CLEAR),
    .en        (state_q == SAMPLE),
    .early_in  (early_lane),
    .late_in   (late_lane),
    .early_cnt (early_cnt),
    .late_cnt  (late_cnt)
  );

  // Window verdict inputs for DECIDE.
  always_comb begin
    diff     = (early_cnt > late_cnt) ? (early_cnt - late_cnt) : (late_cnt - early_cnt);
    dir_now  = (early_cnt > late_cnt) ? DIR_INC : DIR_DEC;
    // A reversal needs a previous move on this lane to reverse against.
    reversal = (steps_q != '0) && (dir_now != last_dir_q);
    oor_seen = oor_pend_q | oor_lane;
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    tap_d      = tap_q;
    steps_d    = steps_q;
    cyc_d      = cyc_q;
    rev_d      = rev_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    oor_pend_d = oor_pend_q;
    lock_d     = lock_q;
    fail_d     = fail_q;
    tap_out_d  = tap_out_q;
`ifdef IOD_TRAIN_PERIODIC_EN
    trk_d    = trk_q;
    armed_d  = armed_q;
    rt_cnt_d = armed_q ? ((rt_cnt_q == RW'(RETRAIN_PERIOD - 1)) ? '0 : rt_cnt_q + RW'(1)) : '0;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = LOAD;
          lane_d  = '0;
          lock_d  = '0;
          fail_d  = '0;
`ifdef IOD_TRAIN_PERIODIC_EN
          trk_d   = 1'b0;
`endif
        end else if (rt_fire) begin
          // Tracking pass: resume each locked lane from its reported tap.
          lane_d     = '0;
          state_d    = lock_q[0] ? CLEAR : NEXT;
          tap_d      = tap_out_q[TAP_W-1:0];
          steps_d    = '0;
          rev_d      = '0;
          last_dir_d = 1'b0;
`ifdef IOD_TRAIN_PERIODIC_EN
          trk_d      = 1'b1;
`endif
        end
      end
      LOAD: begin
        tap_d      = TAP_W'(INIT_TAP);
        steps_d    = '0;
        rev_d      = '0;
        last_dir_d = 1'b0;
        state_d    = CLEAR;
      end
      CLEAR: begin
        oor_pend_d = 1'b0;
        cyc_d      = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        oor_pend_d = oor_seen;
        if (cyc_q == YW'(SETTLE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = SAMPLE;
        end else begin
          cyc_d = cyc_q + YW'(1);
        end
      end
      SAMPLE: begin
        oor_pend_d = oor_seen;
        if (cyc_q == YW'(SAMPLE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = DECIDE;
        end else begin
          cyc_d = cyc_q + YW'(1);
        end
      end
      DECIDE: begin
        state_d = NEXT;
        tap_out_d[int'(lane_q)*TAP_W +: TAP_W] = tap_q;
        if (oor_seen) begin
          fail_d[lane_q] = 1'b1;
          lock_d[lane_q] = 1'b0;
        end else if (int'(diff) <= HYST) begin
          lock_d[lane_q] = 1'b1;
        end else if (reversal && (rev_q == 2'd1)) begin
          // Second reversal: the eye centre sits between two taps.
          lock_d[lane_q] = 1'b1;
        end else if (steps_q == SW'(MAX_STEPS)) begin
          fail_d[lane_q] = 1'b1;
          lock_d[lane_q] = 1'b0;
        end else if ((dir_now == DIR_INC && tap_q == '1) || (dir_now == DIR_DEC && tap_q == '0)) begin
          fail_d[lane_q] = 1'b1;
          lock_d[lane_q] = 1'b0;
        end else begin
          // Keep TAP_OUT unchanged until the lane actually finishes.
          tap_out_d  = tap_out_q;
          state_d    = MOVE;
          dir_d      = dir_now;
          last_dir_d = dir_now;
          tap_d      = (dir_now == DIR_INC) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
          steps_d    = steps_q + SW'(1);
          if (reversal) rev_d = rev_q + 2'd1;
        end
      end
      MOVE: begin
        if (trk) begin
          // One move per lane per tracking pass; report the new tap now.
          tap_out_d[int'(lane_q)*TAP_W +: TAP_W] = tap_q;
          state_d = NEXT;
        end else begin
          state_d = CLEAR;
        end
      end
      NEXT: begin
        if (lane_q == LW'(LANES - 1)) begin
          state_d = DONE_ST;
        end else begin
          lane_d = lane_nx;
          if (trk) begin
            state_d    = lock_q[lane_nx] ? CLEAR : NEXT;
            tap_d      = tap_out_q[int'(lane_nx)*TAP_W +: TAP_W];
            steps_d    = '0;
            rev_d      = '0;
            last_dir_d = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE_ST: begin
        state_d = IDLE;
`ifdef IOD_TRAIN_PERIODIC_EN
        trk_d   = 1'b0;
        armed_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Pulse and status outputs are registered from the next state.
    load_d = (state_d == LOAD)   ? lane_oh(lane_d) : '0;
    clr_d  = (state_d == CLEAR)  ? lane_oh(lane_d) : '0;
    move_d = (state_d == MOVE)   ? lane_oh(lane_d) : '0;
    diro_d = (state_d == MOVE && dir_d == DIR_INC) ? lane_oh(lane_d) : '0;
    busy_d = (state_d != IDLE) && (state_d != DONE_ST);
    done_d = (state_d == DONE_ST);
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      tap_q      <= '0;
      steps_q    <= '0;
      cyc_q      <= '0;
      rev_q      <= '0;
      dir_q      <= 1'b0;
      last_dir_q <= 1'b0;
      oor_pend_q <= 1'b0;
      load_q     <= '0;
      move_q     <= '0;
      diro_q     <= '0;
      clr_q      <= '0;
      lock_q     <= '0;
      fail_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tap_out_q  <= '0;
`ifdef IOD_TRAIN_PERIODIC_EN
      trk_q      <= 1'b0;
      armed_q    <= 1'b0;
      rt_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      tap_q      <= tap_d;
      steps_q    <= steps_d;
      cyc_q      <= cyc_d;
      rev_q      <= rev_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      oor_pend_q <= oor_pend_d;
      load_q     <= load_d;
      move_q     <= move_d;
      diro_q     <= diro_d;
      clr_q      <= clr_d;
      lock_q     <= lock_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tap_out_q  <= tap_out_d;
`ifdef IOD_TRAIN_PERIODIC_EN
      trk_q      <= trk_d;
      armed_q    <= armed_d;
      rt_cnt_q   <= rt_cnt_d;
`endif
    end
  end

  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = diro_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign LANE_LOCK               = lock_q;
  assign LANE_FAIL               = fail_q;
  assign TAP_OUT                 = tap_out_q;

endmodule

// File: doc/pf_iod_dly_train.md
Name: pf_iod_dly_train

Overview:
- Multi-lane RX delay-line training controller for PolarFire IOD lanes (LPDDR3 address/data lanes).
- Drives each lane's dynamic delay line using its eye-monitor EARLY/LATE flags, and reports per-lane lock, failure and final tap.
- Sits in the DDRPHY block between the fabric sequencer and the N IOD instances, clocked by FAB_CLK.
- Successor to single-lane, statically loaded IOD wrappers: lane count, tap width and the decision window are generic.

Parameters:
- LANES, 10: number of IOD lanes trained, processed sequentially from lane 0 to LANES-1.
- TAP_W, 8: tap counter width; legal taps are 0 to 2^TAP_W-1.
- INIT_TAP, 1: tap value assumed after a DELAY_LINE_LOAD pulse.
- SETTLE_CYCLES, 8: wait cycles after a load or move, before sampling.
- SAMPLE_CYCLES, 16: length of the eye-monitor observation window.
- HYST, 2: maximum |early_cnt - late_cnt| treated as centred.
- MAX_STEPS, 64: maximum moves per lane before that lane fails.

Ports:
- FAB_CLK  in  1  fabric clock; all logic rises on it.
- RX_SYNC_RST  in  1  synchronous active-high reset.
- START  in  1  single-cycle pulse; starts training, ignored while BUSY.
- EYE_MONITOR_EARLY  in  LANES  per-lane early flag.
- EYE_MONITOR_LATE  in  LANES  per-lane late flag.
- DELAY_LINE_OUT_OF_RANGE  in  LANES  per-lane range flag.
- DELAY_LINE_LOAD  out  LANES  one-cycle load pulse.
- DELAY_LINE_MOVE  out  LANES  one-cycle move pulse.
- DELAY_LINE_DIRECTION  out  LANES  1 = add delay, 0 = remove delay; valid with MOVE.
- EYE_MONITOR_CLEAR_FLAGS  out  LANES  one-cycle clear pulse.
- BUSY  out  1  high from the cycle after START until DONE.
- DONE  out  1  one-cycle pulse when all lanes are finished.
- LANE_LOCK  out  LANES  sticky per-lane lock flag.
- LANE_FAIL  out  LANES  sticky per-lane failure flag.
- TAP_OUT  out  LANES*TAP_W  final tap per lane; lane i occupies bits [i*TAP_W +: TAP_W].

Behaviour:
- Reset: all outputs 0, TAP_OUT 0, FSM in IDLE, lane index 0.
- Reset during operation aborts immediately; no pulse outputs are issued in the reset cycle.
- FSM states and transitions:
  - IDLE: START moves to LOAD; clears LANE_LOCK, LANE_FAIL and the lane index.
  - LOAD: DELAY_LINE_LOAD[lane]=1 for one cycle; tap:=INIT_TAP, steps:=0, last_dir cleared; then go to CLEAR.
  - CLEAR: EYE_MONITOR_CLEAR_FLAGS[lane]=1 for one cycle; then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: over SAMPLE_CYCLES cycles, early_cnt and late_cnt increment on each cycle the respective flag is high; each counter is clog2(SAMPLE_CYCLES+1) bits and cannot overflow. Then go to DECIDE.
  - DECIDE, in priority order:
    - OUT_OF_RANGE[lane] high: fail.
    - |early_cnt - late_cnt| <= HYST: lock.
    - Computed direction (early > late gives dir=1, else dir=0) opposite to the previous move's direction on the second reversal for this lane: lock (dither detected).
    - steps == MAX_STEPS: fail.
    - tap at 2^TAP_W-1 with dir=1, or tap at 0 with dir=0: fail.
    - Otherwise go to MOVE.
  - MOVE: DELAY_LINE_MOVE[lane]=1 and DIRECTION[lane]=dir for one cycle; tap±1, steps+1; then go to CLEAR.
  - Lock or fail: set LANE_LOCK or LANE_FAIL for the lane, write tap into TAP_OUT, go to NEXT.
  - NEXT: if lane == LANES-1, go to DONE_ST; else lane+1 and go to LOAD.
  - DONE_ST: DONE=1 for one cycle, BUSY falls in the same cycle, return to IDLE.
- OUT_OF_RANGE sampled high in any SETTLE or SAMPLE cycle latches a pending fail; DECIDE honours it.
- Only the active lane's pulse bits are ever non-zero; all other bits stay 0.
- START together with reset: reset wins.
- START while BUSY: ignored.
- Latency per lane with no moves: 1 + 1 + SETTLE_CYCLES + SAMPLE_CYCLES + 1 + 1 cycles.

Optional Feature:
- Macro: IOD_TRAIN_PERIODIC_EN.
- Defined: adds parameter RETRAIN_PERIOD (default 65536) and input RETRAIN_HOLD.
  - After DONE, a free-running counter re-enters tracking when it expires and RETRAIN_HOLD is low.
  - Tracking covers only locked lanes and skips LOAD: CLEAR, SETTLE, SAMPLE, DECIDE, with at most one MOVE per lane per pass.
  - BUSY is high during a pass; DONE pulses at the end.
  - A lane's fail condition during tracking sets LANE_FAIL and clears LANE_LOCK.
- Undefined: no counter and no extra port; the block trains only on START.

Decomposition:
- Package pf_iod_train_pkg holds:
  - the FSM state enum (IDLE, LOAD, CLEAR, SETTLE, SAMPLE, DECIDE, MOVE, NEXT, DONE_ST);
  - the direction constants DIR_INC=1 and DIR_DEC=0;
  - a clog2 width helper for counters.
- One sub-module: pf_iod_train_win_cnt, the early/late window counter with clear, enable and saturation. It is instantiated once and muxed to the active lane.

Test Plan:
- LANES=2, EARLY=LATE=0: START → LANE_LOCK=2'b11, TAP_OUT all INIT_TAP=1, no MOVE pulses, DONE exactly 2*(4+8+16)=56 cycles after START.
- Lane 0 EARLY high until 5 moves taken, then both flags idle: START → 5 MOVE pulses with DIRECTION=1, TAP_OUT[lane0]=6, LOCK[0]=1.
- Lane 0 LATE forced constantly high: START → 1 DEC move (tap 1 to 0), then FAIL[0]=1 at the tap-0 boundary; lane 1 still trains.
- OUT_OF_RANGE[1] pulsed during SAMPLE → FAIL[1]=1, LOCK[1]=0, no further MOVE on lane 1.
- EARLY/LATE alternate each window (dither) → second reversal gives LOCK, steps ≤ 3.
- RX_SYNC_RST asserted mid-SAMPLE: next cycle BUSY=0, all outputs 0; a later START retrains from lane 0.
